// File: rtl/tt_um_unsigned_multiplier.sv
// tt_um_unsigned_multiplier: 8x8 unsigned shift-add multiplier on the Tiny Tapeout tile pinout
module tt_um_unsigned_multiplier #(
  parameter int N_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N_BITS-1:0] a, b, acc, mq, acc_nx, mq_nx;
  logic [N_BITS:0] sum;
  logic [2*N_BITS-1:0] result;
  logic [2:0] cnt;
  logic start_q, done, ovf, start_pulse, loadable, go, last;
  logic unused_uio;
  assign unused_uio = ^uio_in[7:4];
  assign start_pulse = uio_in[0] & ~start_q;
  assign loadable = state != RUN;
  assign go = start_pulse & loadable & ~uio_in[1] & ~uio_in[2];
  assign last = (state == RUN) && (cnt == 3'd7);
  assign sum = {1'b0, acc} + {1'b0, mq[0] ? a : '0};
  assign acc_nx = sum[N_BITS:1];
  assign mq_nx = {sum[0], mq[N_BITS-1:1]};
  assign uo_out = uio_in[3] ? result[15:8] : result[7:0];
  assign uio_out = {1'b0, ovf, done, state == RUN, 4'h0};
  assign uio_oe = 8'hF0;
  // next state: accepted start launches a run, the eighth step finishes it
  always_comb begin
    state_nx = go ? RUN : last ? DONE : state;
  end
  // state register, frozen while the tile is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  end
  // operand loads, shift-add datapath and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      acc <= '0;
      mq <= '0;
      cnt <= '0;
      result <= '0;
      ovf <= 1'b0;
      done <= 1'b0;
      start_q <= 1'b0;
    end else if (ena) begin
      start_q <= uio_in[0];
      if (loadable && uio_in[1]) a <= ui_in;
      if (loadable && uio_in[2]) b <= ui_in;
      if (go) begin
        acc <= '0;
        mq <= b;
        cnt <= '0;
        done <= 1'b0;
      end else if (state == RUN) begin
        acc <= acc_nx;
        mq <= mq_nx;
        cnt <= cnt + 3'd1;
        if (last) begin
          result <= {acc_nx, mq_nx};
          ovf <= |acc_nx;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tt_um_unsigned_multiplier.sv
// tb_tt_um_unsigned_multiplier: scoreboard bench for the sequential multiplier tile
module tb_tt_um_unsigned_multiplier;
  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b1;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int vectors = 0, miscompares = 0;
  logic [15:0] expq[$];
  logic [15:0] exp_v;
  bit ok;

  tt_um_unsigned_multiplier dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // pinout sanity in every state
  always @(negedge clk) begin
    vectors++;
    if (uio_oe !== 8'hF0 || uio_out[3:0] !== 4'h0 || uio_out[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL pinout: uio_oe=%h uio_out=%h, required oe=f0 with [3:0]=0 [7]=0", uio_oe, uio_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input bit st, input bit la, input bit lb);
    uio_in = {5'h0, lb, la, st};
  endtask

  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    ui_in = av; set_ctl(0, 1, 0); tick();
    ui_in = bv; set_ctl(0, 0, 1); tick();
    set_ctl(1, 0, 0);
    expq.push_back(16'(av) * 16'(bv));
    tick();
    set_ctl(0, 0, 0);
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (uio_out[5]) begin got = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: uo_out=%h uio_out=%h, required 00/00", uo_out, uio_out);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    launch(8'd13, 8'd11);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (uio_out[4] !== 1'b1 || uio_out[5] !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, required 1/0", i, uio_out[4], uio_out[5]);
      end
      tick();
    end
    exp_v = expq.pop_front();
    vectors++;
    if (uio_out[5] !== 1'b1 || uio_out[4] !== 1'b0 || uo_out !== exp_v[7:0] || uio_out[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: done=%b busy=%b lo=%h ovf=%b, required 1/0/%h/0", uio_out[5], uio_out[4], uo_out, uio_out[6], exp_v[7:0]);
    end
    uio_in[3] = 1'b1; #1;
    vectors++;
    if (uo_out !== exp_v[15:8]) begin
      miscompares++;
      $display("FAIL basic_hi: uo_out=%h, required %h", uo_out, exp_v[15:8]);
    end
    uio_in[3] = 1'b0;
  endtask

  task automatic test_max();
    logic [7:0] p [2] = '{8'd255, 8'd0};
    logic [7:0] q [2] = '{8'd255, 8'd200};
    for (int k = 0; k < 2; k++) begin
      launch(p[k], q[k]);
      vectors++;
      if (uio_out[5] !== 1'b0) begin
        miscompares++;
        $display("FAIL max_done_clear op %0d: done=%b, required 0", k, uio_out[5]);
      end
      wait_done(ok);
      exp_v = expq.pop_front();
      vectors++;
      if (!ok || uo_out !== exp_v[7:0] || uio_out[6] !== (exp_v[15:8] != 0)) begin
        miscompares++;
        $display("FAIL max_lo op %0d: done=%b lo=%h ovf=%b, required 1/%h/%b", k, ok, uo_out, uio_out[6], exp_v[7:0], exp_v[15:8] != 0);
      end
      uio_in[3] = 1'b1; #1;
      vectors++;
      if (uo_out !== exp_v[15:8]) begin
        miscompares++;
        $display("FAIL max_hi op %0d: uo_out=%h, required %h", k, uo_out, exp_v[15:8]);
      end
      uio_in[3] = 1'b0;
    end
  endtask

  task automatic test_start_held();
    int busy_cnt = 0;
    ui_in = 8'd5; set_ctl(0, 1, 0); tick();
    ui_in = 8'd6; set_ctl(0, 0, 1); tick();
    set_ctl(1, 0, 0);
    expq.push_back(16'd30);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uio_out[4]) busy_cnt++;
    end
    set_ctl(0, 0, 0);
    exp_v = expq.pop_front();
    vectors++;
    if (busy_cnt != 8 || uio_out[5] !== 1'b1 || uo_out !== exp_v[7:0]) begin
      miscompares++;
      $display("FAIL start_held: busy_cycles=%0d done=%b lo=%h, required 8/1/%h", busy_cnt, uio_out[5], uo_out, exp_v[7:0]);
    end
    tick();
  endtask

  task automatic test_start_with_ld();
    ui_in = 8'd9; set_ctl(1, 1, 0); tick();
    set_ctl(0, 0, 0);
    vectors++;
    if (uio_out[4] !== 1'b0 || uio_out[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ld_discard: busy=%b done=%b, required 0/1", uio_out[4], uio_out[5]);
    end
    tick();
    ui_in = 8'd6; set_ctl(0, 0, 1); tick();
    set_ctl(1, 0, 0);
    expq.push_back(16'd54);
    tick();
    set_ctl(0, 0, 0);
    wait_done(ok);
    exp_v = expq.pop_front();
    vectors++;
    if (!ok || uo_out !== exp_v[7:0]) begin
      miscompares++;
      $display("FAIL start_ld_aload: done=%b lo=%h, required 1/%h", ok, uo_out, exp_v[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    launch(8'd12, 8'd10);
    tick(); tick();
    ui_in = 8'd99; set_ctl(1, 0, 1); tick();
    set_ctl(0, 0, 0);
    wait_done(ok);
    exp_v = expq.pop_front();
    vectors++;
    if (!ok || uo_out !== exp_v[7:0] || expq.size() != 0) begin
      miscompares++;
      $display("FAIL run_guard: done=%b lo=%h, required 1/%h", ok, uo_out, exp_v[7:0]);
    end
    tick();
    set_ctl(1, 0, 0);
    expq.push_back(16'd120);
    tick();
    set_ctl(0, 0, 0);
    wait_done(ok);
    exp_v = expq.pop_front();
    vectors++;
    if (!ok || uo_out !== exp_v[7:0]) begin
      miscompares++;
      $display("FAIL run_guard_b_kept: done=%b lo=%h, required 1/%h", ok, uo_out, exp_v[7:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    launch(8'd50, 8'd50);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    void'(expq.pop_back());
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: uo_out=%h uio_out=%h, required 00/00", uo_out, uio_out);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (uio_out[5:4] !== 2'b00 || uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: done/busy=%b uo_out=%h, required 00/00", uio_out[5:4], uo_out);
    end
    launch(8'd7, 8'd9);
    wait_done(ok);
    exp_v = expq.pop_front();
    vectors++;
    if (!ok || uo_out !== exp_v[7:0]) begin
      miscompares++;
      $display("FAIL reset_fresh: done=%b lo=%h, required 1/%h", ok, uo_out, exp_v[7:0]);
    end
  endtask

  task automatic test_ena_freeze();
    launch(8'd100, 8'd3);
    tick(); tick(); tick();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (uio_out[4] !== 1'b1 || uo_out !== 8'h3F) begin
        miscompares++;
        $display("FAIL ena_hold cycle %0d: busy=%b uo_out=%h, required 1/3f", i, uio_out[4], uo_out);
      end
    end
    ena = 1'b1;
    tick(); tick(); tick(); tick();
    vectors++;
    if (uio_out[5] !== 1'b0 || uio_out[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL ena_early: done=%b busy=%b, required 0/1", uio_out[5], uio_out[4]);
    end
    tick();
    exp_v = expq.pop_front();
    vectors++;
    if (uio_out[5] !== 1'b1 || uo_out !== exp_v[7:0] || uio_out[6] !== 1'b1) begin
      miscompares++;
      $display("FAIL ena_result: done=%b lo=%h ovf=%b, required 1/%h/1", uio_out[5], uo_out, uio_out[6], exp_v[7:0]);
    end
    uio_in[3] = 1'b1; #1;
    vectors++;
    if (uo_out !== exp_v[15:8]) begin
      miscompares++;
      $display("FAIL ena_hi: uo_out=%h, required %h", uo_out, exp_v[15:8]);
    end
    uio_in[3] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_start_held();
    test_start_with_ld();
    test_back_to_back();
    test_reset_mid_run();
    test_ena_freeze();
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tt_um_unsigned_multiplier.md
Name: tt_um_unsigned_multiplier

Overview:
8x8 unsigned sequential shift-add multiplier. It produces a 16-bit product and is the inverse-operation companion of the team's unsigned divider tile. It uses the standard Tiny Tapeout user-tile pinout. Operands are loaded byte-wise through ui_in under uio_in strobes, and the product is read back through uo_out one byte at a time. Busy, done and overflow flags are reported on the upper uio pins.

Parameters:
N_BITS, 8, operand width; fixed by the pinout and not to be overridden.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
ena  input  1  tile enable; when 0, all state holds
ui_in  input  8  operand data byte
uio_in  input  8  [0] start, [1] ld_a, [2] ld_b, [3] hi_sel; [7:4] ignored
uo_out  output  8  hi_sel ? result[15:8] : result[7:0]
uio_out  output  8  [3:0]=0, [4] busy, [5] done, [6] ovf, [7]=0
uio_oe  output  8  constant 8'hF0 (uio[7:4] outputs, uio[3:0] inputs)

Behaviour:
- Reset (rst_n=0, async): clear A, B, acc, result, cnt, start_q and done; state=IDLE. uo_out=0 and uio_out=0.
- All registered updates require ena=1. When ena=0, every register holds, including the start edge detector.
- start is rising-edge detected: start_pulse = uio_in[0] & ~start_q, and start_q registers uio_in[0] every enabled cycle. Holding start high launches one operation only.
- States:
  - IDLE: initial state after reset.
  - RUN: the multiply is in progress.
  - DONE: the result is valid.
- Operand loads:
  - Allowed in IDLE or DONE only.
  - ld_a=1 loads A <= ui_in; ld_b=1 loads B <= ui_in; both high loads both with the same byte.
  - Ignored in RUN.
- Launching an operation:
  - A start_pulse in IDLE or DONE with ld_a=ld_b=0 enters RUN: acc <= 0, mq <= B, cnt <= 0, done <= 0.
  - A start_pulse in the same cycle as any ld strobe is discarded. The load still happens.
  - A start_pulse in RUN is ignored. The edge detector still updates.
- RUN step, once per enabled cycle:
  - If mq[0], acc_hi <= acc_hi + A with 9-bit carry.
  - Then {carry, acc_hi, mq} shifts right by 1.
  - cnt increments.
- After the 8th RUN cycle (cnt==7 at the edge):
  - result <= {acc_hi, mq} (16 bits).
  - state <= DONE, done <= 1.
- Latency: start_pulse sampled at edge k means done=1 and the result is valid after edge k+8.
- busy = (state==RUN). done stays 1 in DONE until the next accepted start.
- ovf = (result[15:8] != 0); it is registered together with result.
- result and ovf change only on completion. uo_out therefore shows the previous product, stable, throughout RUN.
- hi_sel is combinational on uo_out and is valid in any state.
- Reset mid-RUN aborts the operation and clears everything as above; no partial result is kept.
- Arithmetic is exact for all 65,536 operand pairs. Maximum is 255*255 = 0xFE01, so there is no truncation.

Test Plan:
- Basic multiply: ld_a ui=13, ld_b ui=11, start pulse -> busy=1 for 8 cycles. Then done=1, uo_out=0x8F (hi_sel=0), uo_out=0x00 (hi_sel=1), ovf=0.
- Max operands: A=255, B=255 -> result 0xFE01, low byte 0x01, high byte 0xFE, ovf=1. Next op A=0, B=200 -> result 0, ovf=0, done re-asserts.
- Handshake guards:
  - start held high for 20 cycles -> exactly one operation.
  - start and ld_a in the same cycle -> A loaded, no RUN.
  - Second start pulse and ld_b at RUN cycle 3 -> ignored; result unchanged from the first op.
- Reset mid-operation: rst_n low at RUN cycle 4, asynchronously and off the clock edge -> uo_out=0 and uio_out=0 immediately. After release, state=IDLE and done=0. A fresh 7*9 gives 0x3F.
- ena freeze: deassert ena for 5 cycles mid-RUN -> busy, cnt and acc hold. Total completion is delayed by 5 cycles. 100*3 still gives 0x012C with ovf=1.
- Pinout sanity: uio_oe==0xF0 always; uio_out[3:0]==0 and uio_out[7]==0 in every state.
